// File: rtl/lfsr8_checker.sv
// lfsr8_checker
//
// Receive-side checker for the 8-bit PRBS stream b[n] = b[n-4]^b[n-5]^b[n-6]^b[n-8].
// It fills a local history from the incoming bits (HUNT) and confirms a run of correct
// predictions (VERIFY). It then free-runs its own copy of the sequence (LOCK) and counts
// received bits that disagree with it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         bit-accept strobe; d_in is sampled only when en=1
//   d_in       received serial bit
//   clr        synchronous clear of err_count (acts regardless of en)
//   locked     high while in LOCK
//   err        one-cycle pulse per mismatch detected in LOCK
//   err_count  saturating error total (0..255)
//   state      0=HUNT, 1=VERIFY, 2=LOCK
module lfsr8_checker #(
    parameter int unsigned VERIFY_LEN = 16,
    parameter int unsigned WIN_LEN    = 32,
    parameter int unsigned LOSS_ERRS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       d_in,
    input  logic       clr,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [1:0] state
);

    localparam int unsigned MW = $clog2(VERIFY_LEN + 1);
    localparam int unsigned WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned EW = $clog2(LOSS_ERRS + 1);

    localparam logic [MW-1:0] MatchLast = MW'(VERIFY_LEN - 1);
    localparam logic [WW-1:0] WinLast   = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] ErrLast   = EW'(LOSS_ERRS - 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLock   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    h_q, h_d;
    logic [2:0]    fill_q, fill_d;
    logic [MW-1:0] match_q, match_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] werr_q, werr_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic pred;
    logic is_match;
    logic hit;

    // h_q[0] is the newest bit, so h_q[k] holds b[n-1-k].
    assign pred     = h_q[3] ^ h_q[4] ^ h_q[5] ^ h_q[7];
    // An all-zero history predicts zeros forever; refuse to call that a match.
    assign is_match = (d_in == pred) && (h_q != 8'd0);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        hit     = 1'b0;

        if (en) begin
            unique case (state_q)
                StHunt: begin
                    h_d = {h_q[6:0], d_in};
                    if (fill_q == 3'd7) begin
                        state_d = StVerify;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                StVerify: begin
                    h_d = {h_q[6:0], d_in};
                    if (is_match) begin
                        if (match_q == MatchLast) begin
                            state_d = StLock;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        state_d = StHunt;
                        fill_d  = '0;
                    end
                end
                StLock: begin
                    // Flywheel: shift in our own prediction so one bad bit costs one error.
                    h_d   = {h_q[6:0], pred};
                    win_d = win_q + 1'b1;
                    if (!is_match) begin
                        hit    = 1'b1;
                        werr_d = werr_q + 1'b1;
                    end
                    // Loss check sees the closing bit's error before the window clears.
                    if (!is_match && (werr_q == ErrLast)) begin
                        state_d = StHunt;
                        fill_d  = '0;
                    end else if (win_q == WinLast) begin
                        werr_d = '0;
                    end
                end
                default: begin
                    state_d = StHunt;
                    fill_d  = '0;
                end
            endcase
        end

        err_d = hit;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = hit ? 8'd1 : 8'd0;
        end else if (hit && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHunt;
            h_q     <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked    = (state_q == StLock);
    assign err       = err_q;
    assign err_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr8_checker.sv
module tb_lfsr8_checker;

    localparam int VERIFY_LEN = 16;
    localparam int WIN_LEN    = 32;
    localparam int LOSS_ERRS  = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d_in;
    logic       clr;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [1:0] state;

    lfsr8_checker #(
        .VERIFY_LEN (VERIFY_LEN),
        .WIN_LEN    (WIN_LEN),
        .LOSS_ERRS  (LOSS_ERRS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .d_in      (d_in),
        .clr       (clr),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the last 8 accepted/flywheel bits as a queue (index 7 = newest)
    // and plain integer counters for the protocol rules.
    bit hist[$];
    int m_state;
    int m_fill;
    int m_match;
    int m_win;
    int m_werr;
    int m_cnt;
    bit m_err;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        m_state = 0;
        m_fill  = 0;
        m_match = 0;
        m_win   = 0;
        m_werr  = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_push(input bit b);
        hist.push_back(b);
        void'(hist.pop_front());
    endtask

    task automatic model_step(input bit e, input bit d, input bit c);
        bit p;
        bit nz;
        bit ok;
        bit hit;
        hit = 1'b0;
        if (e) begin
            // b[n-4], b[n-5], b[n-6], b[n-8]
            p  = hist[4] ^ hist[3] ^ hist[2] ^ hist[0];
            nz = 1'b0;
            for (int i = 0; i < 8; i++) if (hist[i]) nz = 1'b1;
            ok = (d == p) && nz;
            if (m_state == 0) begin
                model_push(d);
                m_fill++;
                if (m_fill == 8) begin
                    m_state = 1;
                    m_match = 0;
                end
            end else if (m_state == 1) begin
                model_push(d);
                if (ok) begin
                    m_match++;
                    if (m_match == VERIFY_LEN) begin
                        m_state = 2;
                        m_win   = 0;
                        m_werr  = 0;
                    end
                end else begin
                    m_state = 0;
                    m_fill  = 0;
                end
            end else begin
                model_push(p);
                m_win++;
                if (!ok) begin
                    hit = 1'b1;
                    m_werr++;
                end
                if (m_werr == LOSS_ERRS) begin
                    m_state = 0;
                    m_fill  = 0;
                end else if (m_win == WIN_LEN) begin
                    m_win  = 0;
                    m_werr = 0;
                end
            end
        end
        m_err = hit;
        if (c) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < 255) m_cnt++;
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    bit saw_lock;
    bit saw_hunt;
    bit saw_verify;
    int n_err_pulses;

    always @(negedge clk) begin
        check("cyc_locked", int'(locked), (m_state == 2) ? 1 : 0);
        check("cyc_err", int'(err), int'(m_err));
        check("cyc_err_count", int'(err_count), m_cnt);
        check("cyc_state", int'(state), m_state);
        if (locked === 1'b1) saw_lock = 1'b1;
        if (state === 2'd0) saw_hunt = 1'b1;
        if (state === 2'd1) saw_verify = 1'b1;
        if (err === 1'b1) n_err_pulses++;
    end

    // PRBS generator state, newest bit in [0].
    logic [7:0] g;

    function automatic logic [7:0] gen_adv(input logic [7:0] s);
        return {s[6:0], s[3] ^ s[4] ^ s[5] ^ s[7]};
    endfunction

    task automatic step(input bit e, input bit d, input bit c);
        en   = e;
        d_in = d;
        clr  = c;
        @(posedge clk);
        model_step(e, d, c);
        #1;
    endtask

    task automatic send(input bit flip, input bit c);
        g = gen_adv(g);
        step(1'b1, g[0] ^ flip, c);
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 200) begin
            send(1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic align_window();
        int k;
        k = 0;
        while (m_win != 0 && k < 64) begin
            send(1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic send_pattern(input int len, input int f0, input int f1, input int f2,
                                input int f3);
        for (int o = 0; o < len; o++) begin
            send((o == f0) || (o == f1) || (o == f2) || (o == f3), 1'b0);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] gs;
        logic [7:0] v;
        int offs[4];
        int nf;
        int o;
        int it;

        n_vec = 0;
        n_bad = 0;
        n_err_pulses = 0;
        saw_lock = 1'b0;
        saw_hunt = 1'b0;
        saw_verify = 1'b0;
        en = 1'b0;
        d_in = 1'b0;
        clr = 1'b0;
        rst_n = 1'b0;
        g = 8'h01;
        model_reset();

        // Pin the generator: seed 0x01 emits 0,0,0,1,1,1,0,0 and has period 255.
        gs = 8'h01;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            gs = gen_adv(gs);
            v = {v[6:0], gs[0]};
        end
        check("gen_first8", int'(v), 8'h1C);
        gs = gen_adv(8'h01);
        n = 1;
        while (gs != 8'h01 && n < 1000) begin
            gs = gen_adv(gs);
            n++;
        end
        check("gen_period", n, 255);

        // Reset state.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;

        // Clean stream, seed 0x01, 600 bits.
        g = 8'h01;
        n_err_pulses = 0;
        for (int i = 1; i <= 600; i++) begin
            send(1'b0, 1'b0);
            if (i == 23) check("clean_lock_b23", int'(locked), 0);
            if (i == 24) begin
                check("clean_lock_b24", int'(locked), 1);
                check("model_lock_b24", m_state, 2);
            end
        end
        check("clean_err_count", int'(err_count), 0);
        check("clean_err_pulses", n_err_pulses, 0);

        // Single flipped bit with random EN gaps.
        n_err_pulses = 0;
        n = $urandom_range(10, 80);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send(i == n, 1'b0);
        end
        check("single_err_count", int'(err_count), 1);
        check("single_err_pulses", n_err_pulses, 1);
        check("single_locked", int'(locked), 1);

        // CLR with EN low, then a 4-error burst within 20 bits of one window.
        step(1'b0, 1'b0, 1'b1);
        check("clr_no_en", int'(err_count), 0);
        align_window();
        offs[0] = $urandom_range(0, 4);
        for (int i = 1; i < 4; i++) offs[i] = offs[i-1] + $urandom_range(1, 5);
        nf = 0;
        o = 0;
        while (nf < 4 && o < 40) begin
            if (o == offs[nf]) begin
                send(1'b1, 1'b0);
                nf++;
                if (nf == 3) check("burst_hold3", int'(locked), 1);
            end else begin
                send(1'b0, 1'b0);
            end
            o++;
        end
        check("burst_drop4", int'(locked), 0);
        check("burst_err_pulse", int'(err), 1);
        check("burst_err_count", int'(err_count), 4);
        wait_lock(n);
        check("burst_relock_len", n, 24);
        check("burst_relock_cnt", int'(err_count), 4);

        // 3 errors (last on the closing bit) then 1 in the next window: lock held.
        align_window();
        send_pattern(64, $urandom_range(0, 10), $urandom_range(11, 25), 31,
                     32 + $urandom_range(0, 31));
        check("win_split_locked", int'(locked), 1);
        check("win_split_cnt", int'(err_count), 8);

        // 4th error on the WIN_LEN-th bit still drops lock.
        align_window();
        send_pattern(31, $urandom_range(0, 9), $urandom_range(10, 19),
                     $urandom_range(20, 30), -1);
        check("win_edge_hold", int'(locked), 1);
        send(1'b1, 1'b0);
        check("win_edge_drop", int'(locked), 0);
        check("win_edge_cnt", int'(err_count), 12);
        wait_lock(n);
        check("win_edge_relock", n, 24);

        // Asynchronous reset mid-lock takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", int'(locked), 0);
        check("async_rst_err", int'(err), 0);
        check("async_rst_cnt", int'(err_count), 0);
        check("async_rst_state", int'(state), 0);
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Stuck-at inputs never lock and bounce between HUNT and VERIFY.
        saw_lock = 1'b0;
        saw_hunt = 1'b0;
        saw_verify = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        check("const0_no_lock", int'(saw_lock), 0);
        check("const0_hunt", int'(saw_hunt), 1);
        check("const0_verify", int'(saw_verify), 1);
        saw_lock = 1'b0;
        saw_hunt = 1'b0;
        saw_verify = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);
        check("const1_no_lock", int'(saw_lock), 0);
        check("const1_hunt", int'(saw_hunt), 1);
        check("const1_verify", int'(saw_verify), 1);

        // EN every third cycle, random seed: lock after exactly 24 accepted bits.
        pulse_reset();
        g = 8'($urandom_range(1, 255));
        for (int i = 1; i <= 40; i++) begin
            idle();
            idle();
            send(1'b0, 1'b0);
            if (i == 23) check("engap_lock_b23", int'(locked), 0);
            if (i == 24) check("engap_lock_b24", int'(locked), 1);
        end

        // CLR in the same cycle as an error leaves a count of 1.
        send(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        check("pre_clr_cnt", int'(err_count), 2);
        send(1'b1, 1'b1);
        check("clr_err_cnt", int'(err_count), 1);
        check("clr_err_pulse", int'(err), 1);

        // 300 forced errors with repeated relock: count saturates.
        nf = 0;
        it = 0;
        while (nf < 300 && it < 8000) begin
            if (m_state == 2) begin
                send(1'b1, 1'b0);
                nf++;
            end else begin
                send(1'b0, 1'b0);
            end
            it++;
        end
        check("sat_flips", nf, 300);
        check("sat_model", m_cnt, 255);
        check("sat_err_count", int'(err_count), 255);
        step(1'b0, 1'b0, 1'b1);
        check("sat_clr", int'(err_count), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
